// File: rtl/bus_expander_arbiter.sv
// Two-port command arbiter and address/data sequencer for the bus expander master side.
// Optional round-robin tie-breaking is enabled by defining EXPANDER_ARB_RR_EN.
module bus_expander_arbiter #(
  parameter int unsigned NUM_REGS = 65536
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [15:0] rdata,
  input  logic        hold,
  output logic        busy,
  output logic [15:0] exp_data_in,
  output logic        exp_address_load,
  output logic        exp_data_load,
  output logic        exp_data_read,
  input  logic [15:0] exp_data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StRd1,
    StRd2,
    StRcap,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;

  logic        grant_en;
  logic        pick1;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic        in_range;

  assign grant_en = (state_q == StIdle) && !hold && (req0 || req1);

`ifdef EXPANDER_ARB_RR_EN
  // last_q remembers the most recently granted port; a tie goes to the other one.
  logic last_q, last_d;

  assign pick1  = req1 && (!req0 || !last_q);
  assign last_d = grant_en ? pick1 : last_q;

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick1 = req1 && !req0;
`endif

  assign gnt0 = grant_en && !pick1;
  assign gnt1 = grant_en && pick1;

  assign sel_we    = pick1 ? we1    : we0;
  assign sel_addr  = pick1 ? addr1  : addr0;
  assign sel_wdata = pick1 ? wdata1 : wdata0;
  assign in_range  = 32'(sel_addr) < NUM_REGS;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_en) begin
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          owner_d = pick1;
          err_d   = !in_range;
          // Out-of-range commands skip the expander entirely.
          state_d = in_range ? StAddr : StDone;
        end
      end
      StAddr:  state_d = we_q ? StWdata : StRd1;
      StWdata: state_d = StDone;
      StRd1:   state_d = StRd2;
      StRd2:   state_d = StRcap;
      StRcap: begin
        rdata_d = exp_data_out;
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // All strobes decode from registered state, so at most one is ever high.
  always_comb begin
    exp_address_load = 1'b0;
    exp_data_load    = 1'b0;
    exp_data_read    = 1'b0;
    exp_data_in      = 16'h0000;
    done0            = 1'b0;
    done1            = 1'b0;
    err              = 1'b0;
    unique case (state_q)
      StAddr: begin
        exp_address_load = 1'b1;
        exp_data_in      = addr_q;
      end
      StWdata: begin
        exp_data_load = 1'b1;
        exp_data_in   = wdata_q;
      end
      StRd1, StRd2: exp_data_read = 1'b1;
      StDone: begin
        done0 = !owner_q;
        done1 = owner_q;
        err   = err_q;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign rdata = rdata_q;

endmodule

// File: doc/bus_expander_arbiter.md
# bus_expander_arbiter

Two-port arbiter and sequencer for the bus expander's master side. It accepts single-register read and write commands from two requesters: port 0 is the MCU core glue, port 1 is the debugger. It grants one command at a time and drives the expander's address register and data register in the mandatory order: address first, then one data write or two consecutive data reads. It returns read data and a completion pulse to the granted requester, and reports a busy window to the debugger so that a break never lands inside a pending expander access.

## Interface
- `NUM_REGS`, default 65536: number of expander slave registers. Command addresses ≥ `NUM_REGS` are rejected.
- `sysclk` in 1: the single clock. All state changes on its rising edge.
- `sysreset` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: command request. Held high until the matching grant is seen.
- `we0`, `we1` in 1: 1 = write, 0 = read. Valid while the matching req is high.
- `addr0`, `addr1` in 16: target expander register.
- `wdata0`, `wdata1` in 16: write data.
- `gnt0`, `gnt1` out 1: combinational, one-hot. Command is accepted in the cycle where req and gnt are both high.
- `done0`, `done1` out 1: one-cycle completion pulse to the owner of the accepted command.
- `err` out 1: valid with done. 1 = address out of range.
- `rdata` out 16: registered read data, shared by both ports. Valid from the done cycle until the next read completes.
- `hold` in 1: debugger freeze. While high, no new grant is issued; an in-flight command still completes.
- `busy` out 1: high in every non-IDLE state.
- `exp_data_in` out 16: drives the expander's data_in.
- `exp_address_load`, `exp_data_load`, `exp_data_read` out 1: expander strobes.
- `exp_data_out` in 16: the expander's data register output.

## Operation
- States: IDLE, ADDR, WDATA, RD1, RD2, RCAP, DONE.
- **IDLE**
  - Grants when any req is high and hold is low. On grant, latches we, addr and wdata from the granted port and records the owner.
  - If `addr ≥ NUM_REGS`: goes to DONE with err=1. No expander strobes; rdata is unchanged.
  - Otherwise goes to ADDR.
- **ADDR:** `exp_address_load`=1, `exp_data_in`=addr. Next state is WDATA if we=1, else RD1.
- **WDATA:** `exp_data_load`=1, `exp_data_in`=wdata. Next state DONE.
- **RD1:** `exp_data_read`=1. This is the throwaway read. Next state RD2.
- **RD2:** `exp_data_read`=1. The peripheral sees its read strobe here. Next state RCAP.
- **RCAP:** rdata ← `exp_data_out` at the end of the cycle. Next state DONE.
- **DONE:** the owner's done pulses, with err valid. Next state IDLE.
- Strobes are decoded from registered state only. They are never asserted in two different states in the same cycle.
- `exp_data_in` is 0 in all states other than ADDR and WDATA.
- A request arriving in a non-IDLE state waits, and is arbitrated on return to IDLE.
- A req dropped before grant is a legal cancel.
- Arbitration applies only when req0 and req1 are both high in IDLE; the policy is set under Configuration.
- If hold rises mid-command, the command runs to DONE and then stays in IDLE until hold falls.
- Reset:
  - State = IDLE. gnt, done, err, busy and all `exp_*` strobes = 0. `exp_data_in` = 0, rdata = 0.
  - The round-robin pointer favours port 0.
  - Reset in any state aborts the command, and no done is issued.

## Timing
- Cycle 0 = grant cycle (IDLE, req & gnt).
- In-range write:
  - ADDR in cycle 1, WDATA in cycle 2, done in cycle 3.
  - The peripheral's load strobe occurs in cycle 3.
  - Next grant at cycle 4 at the earliest.
- In-range read:
  - ADDR in cycle 1, RD1 in cycle 2, RD2 in cycle 3, RCAP in cycle 4.
  - done in cycle 5, with rdata valid in cycle 5.
  - Next grant at cycle 6 at the earliest.
- Out-of-range command: done with err in cycle 1.
- busy is high from cycle 1 through the done cycle.

## Configuration
- `EXPANDER_ARB_RR_EN` defined:
  - Round-robin on ties. A one-bit pointer records the last granted port, and a tie goes to the other port.
  - The pointer updates only on grant.
  - After reset, a tie grants port 0.
- Not defined:
  - Fixed priority. Port 0 always wins a tie. No pointer register exists.

## Test plan
- **Write.** req0, we0=1, addr0=0x0005, wdata0=0xBEEF in cycle 0. Expected:
  - gnt0 in cycle 0.
  - `exp_address_load` with `exp_data_in`=0x0005 in cycle 1.
  - `exp_data_load` with 0xBEEF in cycle 2.
  - done0 in cycle 3, err=0.
- **Read.** req1, we1=0, addr1=0x0002; model returns 0x1234 after the second data_read. Expected:
  - `exp_data_read` high in cycles 2 and 3 only.
  - done1 in cycle 5, rdata=0x1234.
- **Tie.** req0 and req1 both held for two commands.
  - With RR: grants are port 0 then port 1.
  - Without RR: port 0 is granted twice.
- **Out of range.** `NUM_REGS`=8, read of addr0=0x0008. Expected:
  - done0 in cycle 1, err=1.
  - No `exp_*` strobe; rdata unchanged.
- **Hold and reset.**
  - hold raised in RD1: the read completes at cycle 5, and a pending req1 gets no grant until hold falls.
  - sysreset in WDATA: next cycle state=IDLE, all strobes 0, no done.
